// File: rtl/wb_traffic_gen_if.sv
// Wishbone B4 master-side bundle between the traffic generator and the SDRAM
// controller's wishbone slave port.
interface wb_traffic_gen_if #(
  parameter int unsigned AW = 26,
  parameter int unsigned DW = 32
) ();

  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_we_o;
  logic [3:0]    wb_sel_o;
  logic [AW-1:0] wb_addr_o;
  logic [DW-1:0] wb_dat_o;
  logic [2:0]    wb_cti_o;
  logic          wb_ack_i;
  logic [DW-1:0] wb_dat_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_addr_o, wb_dat_o, wb_cti_o,
    input  wb_ack_i, wb_dat_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_addr_o, wb_dat_o, wb_cti_o,
    output wb_ack_i, wb_dat_i
  );

endinterface

// File: rtl/wb_traffic_gen.sv
// Wishbone B4 burst traffic generator / BIST: writes an address-derived pattern
// over a region in incrementing bursts, reads it back and checks every beat.
module wb_traffic_gen #(
  parameter int unsigned   DW         = 32,
  parameter int unsigned   AW         = 26,
  parameter int unsigned   BURST_LEN  = 8,
  parameter int unsigned   NUM_BURSTS = 4,
  parameter logic [AW-1:0] BASE_ADDR  = '0,
  parameter logic [DW-1:0] SEED       = 32'hA5A5_0000,
  parameter int unsigned   TIMEOUT    = 1024
) (
  input  logic                    sys_clk,
  input  logic                    RESETN,
  input  logic                    start,
  input  logic                    sdr_init_done,
  wb_traffic_gen_if.master        wb,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    timeout,
  output logic [15:0]             err_cnt,
  output logic [AW-1:0]           first_err_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_INIT,
    S_WR,
    S_WR_GAP,
    S_RD,
    S_RD_GAP,
    S_DONE
  } state_t;

  localparam logic [5:0]  LAST_BEAT  = 6'(BURST_LEN - 1);
  localparam logic [8:0]  LAST_BURST = 9'(NUM_BURSTS - 1);
  localparam logic [31:0] TIMEOUT_M1 = 32'(TIMEOUT - 1);

  state_t        state;
  state_t        state_nxt;
  logic [5:0]    beat_cnt;
  logic [8:0]    burst_cnt;
  logic [31:0]   wait_cnt;
  logic [31:0]   beat_idx;
  logic [AW-1:0] beat_addr;
  logic [DW-1:0] pattern;
  logic          in_burst;
  logic          beat_ack;
  logic          last_beat;
  logic          last_burst;
  logic          stall_hit;
  logic          mismatch;
  logic          start_ok;
  logic [15:0]   err_cnt_nxt;

  // Address and pattern are derived from the beat position, so retries after a
  // wait state never need separate holding registers.
  always_comb begin
    beat_idx  = 32'(burst_cnt) * 32'(BURST_LEN) + 32'(beat_cnt);
    beat_addr = BASE_ADDR + AW'(beat_idx << 2);
    pattern   = DW'(beat_addr) ^ SEED;
  end

  assign in_burst   = (state == S_WR) || (state == S_RD);
  assign beat_ack   = in_burst && wb.wb_ack_i;
  assign last_beat  = (beat_cnt == LAST_BEAT);
  assign last_burst = (burst_cnt == LAST_BURST);
  assign stall_hit  = in_burst && !wb.wb_ack_i && (wait_cnt == TIMEOUT_M1);
  assign mismatch   = beat_ack && (state == S_RD) && (wb.wb_dat_i != pattern);
  assign start_ok   = (state == S_IDLE) && start;
  assign busy       = (state != S_IDLE) && (state != S_DONE);

  assign err_cnt_nxt = (mismatch && (err_cnt != 16'hFFFF)) ? err_cnt + 16'd1 : err_cnt;

  assign wb.wb_cyc_o  = in_burst;
  assign wb.wb_stb_o  = in_burst;
  assign wb.wb_we_o   = (state == S_WR);
  assign wb.wb_sel_o  = in_burst ? 4'hF : 4'h0;
  assign wb.wb_addr_o = in_burst ? beat_addr : '0;
  assign wb.wb_dat_o  = (state == S_WR) ? pattern : '0;
  assign wb.wb_cti_o  = in_burst ? (last_beat ? 3'b111 : 3'b010) : 3'b000;

  always_ff @(posedge sys_clk) begin
    if (!RESETN) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // burst_cnt wraps to 0 after the last write burst, which is how WR_GAP knows
  // the write phase is over (also correct for a single burst per pass).
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_WAIT_INIT;
      end
      S_WAIT_INIT: begin
        if (sdr_init_done) state_nxt = S_WR;
      end
      S_WR: begin
        if (beat_ack && last_beat) state_nxt = S_WR_GAP;
        else if (stall_hit)        state_nxt = S_DONE;
      end
      S_WR_GAP: begin
        state_nxt = (burst_cnt == 9'd0) ? S_RD : S_WR;
      end
      S_RD: begin
        if (beat_ack && last_beat) state_nxt = last_burst ? S_DONE : S_RD_GAP;
        else if (stall_hit)        state_nxt = S_DONE;
      end
      S_RD_GAP: begin
        state_nxt = S_RD;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!RESETN) begin
      beat_cnt       <= '0;
      burst_cnt      <= '0;
      wait_cnt       <= '0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
    end else if (start_ok) begin
      beat_cnt       <= '0;
      burst_cnt      <= '0;
      wait_cnt       <= '0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
    end else begin
      if (beat_ack) begin
        wait_cnt <= '0;
        beat_cnt <= last_beat ? 6'd0 : beat_cnt + 6'd1;
        if (last_beat) begin
          burst_cnt <= last_burst ? 9'd0 : burst_cnt + 9'd1;
        end
      end else if (in_burst) begin
        wait_cnt <= wait_cnt + 32'd1;
      end

      if (mismatch) begin
        err_cnt <= err_cnt_nxt;
        if (err_cnt == 16'd0) first_err_addr <= beat_addr;
      end

      // Status uses the next error count so a mismatch on the final beat counts.
      if (state_nxt == S_DONE) begin
        done    <= 1'b1;
        timeout <= stall_hit;
        pass    <= !stall_hit && (err_cnt_nxt == 16'd0);
      end
    end
  end

endmodule
